// File: rtl/link_failover_ctrl.sv
// link_failover_ctrl: picks one of two redundant GMII upstream links (A/B)
// for the output path. Each link has a health monitor that tracks PHY status,
// idle timeout and errored-frame rate. A four-state FSM moves 'select' only
// inside an inter-frame gap of the currently active link. It applies a
// hold-off after every switch, and it supports forced and revertive operation.
`timescale 1ns/1ps

module link_failover_ctrl #(
    parameter int TIMEOUT_CLOCKS = 50000,
    parameter int ERR_LIMIT      = 4,
    parameter int ERR_WINDOW     = 65536,
    parameter int HOLDOFF_CLOCKS = 1024,
    parameter int GAP_CLOCKS     = 12,
    parameter int REVERTIVE      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_dv,
    input  logic       a_er,
    input  logic       a_up,
    input  logic       b_dv,
    input  logic       b_er,
    input  logic       b_up,
    input  logic       force_en,
    input  logic       force_sel,
    output logic       select,
    output logic       switch_pulse,
    output logic       a_healthy,
    output logic       b_healthy,
    output logic [1:0] state
);

    localparam int IW = $clog2(TIMEOUT_CLOCKS + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int HW = $clog2(HOLDOFF_CLOCKS + 1);

    localparam logic [IW-1:0] TIMEOUT_V = IW'(TIMEOUT_CLOCKS);
    localparam logic [IW-1:0] GAP_V     = IW'(GAP_CLOCKS);
    localparam logic [EW-1:0] ERR_V     = EW'(ERR_LIMIT);
    localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
    localparam logic [HW-1:0] HOLD_V    = HW'(HOLDOFF_CLOCKS);
    localparam bit            REV       = (REVERTIVE != 0);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_TO_B = 2'd1,
        S_B    = 2'd2,
        S_TO_A = 2'd3
    } state_t;

    // Index 0 is link A and index 1 is link B.
    logic [1:0] link_dv;
    logic [1:0] link_er;
    logic [1:0] link_up;
    logic [1:0] link_healthy;
    logic [1:0] gap_met;

    assign link_dv = {b_dv, a_dv};
    assign link_er = {b_er, a_er};
    assign link_up = {b_up, a_up};

    // Shared error window. Its wrap clears both error counters.
    logic [WW-1:0] win_cnt_q;
    logic [WW-1:0] win_cnt_d;
    logic          win_wrap;

    // Free-running window counter, wrapping at ERR_WINDOW-1.
    always_comb begin
        win_wrap  = (win_cnt_q == WIN_LAST);
        win_cnt_d = win_wrap ? '0 : win_cnt_q + WW'(1);
    end

    // Window counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_link
            logic [IW-1:0] idle_cnt_q;
            logic [IW-1:0] idle_cnt_d;
            logic [EW-1:0] err_cnt_q;
            logic [EW-1:0] err_cnt_d;
            logic          dv_prev_q;
            logic          dv_prev_d;
            logic          frame_err_q;
            logic          frame_err_d;
            logic          healthy_q;
            logic          healthy_d;
            logic          frame_end;

            assign frame_end = dv_prev_q && !link_dv[gi];

            // Idle timeout, errored-frame tracking and the health verdict.
            // A frame is tagged errored if er is seen with dv during the frame.
            // The tag is consumed on the dv falling edge.
            always_comb begin
                idle_cnt_d = idle_cnt_q;
                if (link_dv[gi]) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != TIMEOUT_V) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end

                dv_prev_d   = link_dv[gi];
                frame_err_d = frame_end ? 1'b0 : (frame_err_q || (link_dv[gi] && link_er[gi]));

                err_cnt_d = err_cnt_q;
                if (!link_up[gi] || win_wrap) begin
                    err_cnt_d = '0;
                end else if (frame_end && frame_err_q && (err_cnt_q != ERR_V)) begin
                    err_cnt_d = err_cnt_q + EW'(1);
                end

                healthy_d = link_up[gi] && (idle_cnt_q < TIMEOUT_V) && (err_cnt_q < ERR_V);
            end

            // Per-link monitor registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    idle_cnt_q  <= '0;
                    err_cnt_q   <= '0;
                    dv_prev_q   <= 1'b0;
                    frame_err_q <= 1'b0;
                    healthy_q   <= 1'b0;
                end else begin
                    idle_cnt_q  <= idle_cnt_d;
                    err_cnt_q   <= err_cnt_d;
                    dv_prev_q   <= dv_prev_d;
                    frame_err_q <= frame_err_d;
                    healthy_q   <= healthy_d;
                end
            end

            // A gap is usable only once it is long enough. The link must also
            // not be starting a frame at the edge where select would move.
            assign gap_met[gi]      = (idle_cnt_q >= GAP_V) && !link_dv[gi];
            assign link_healthy[gi] = healthy_q;
        end
    endgenerate

    state_t        state_q;
    state_t        state_d;
    logic          select_q;
    logic          select_d;
    logic          switch_pulse_q;
    logic          switch_pulse_d;
    logic [HW-1:0] holdoff_q;
    logic [HW-1:0] holdoff_d;
    logic          holdoff_zero;
    logic          want_b;
    logic          want_a;

    assign holdoff_zero = (holdoff_q == '0);

    // Next-state logic. Force overrides health and hold-off. The gap
    // requirement always applies. An automatic move needs the target link
    // to be healthy, so the FSM stays put when both links are bad.
    always_comb begin
        want_b = force_en ? force_sel
                          : (!link_healthy[0] && link_healthy[1] && holdoff_zero);
        want_a = force_en ? !force_sel
                          : (link_healthy[0] && holdoff_zero && (REV || !link_healthy[1]));

        state_d        = state_q;
        select_d       = select_q;
        switch_pulse_d = 1'b0;
        holdoff_d      = holdoff_zero ? holdoff_q : holdoff_q - HW'(1);

        case (state_q)
            S_A: begin
                if (want_b) begin
                    state_d = S_TO_B;
                end
            end
            S_TO_B: begin
                if (!want_b) begin
                    state_d = S_A;
                end else if (gap_met[0]) begin
                    state_d        = S_B;
                    select_d       = 1'b1;
                    switch_pulse_d = 1'b1;
                    holdoff_d      = HOLD_V;
                end
            end
            S_B: begin
                if (want_a) begin
                    state_d = S_TO_A;
                end
            end
            S_TO_A: begin
                if (!want_a) begin
                    state_d = S_B;
                end else if (gap_met[1]) begin
                    state_d        = S_A;
                    select_d       = 1'b0;
                    switch_pulse_d = 1'b1;
                    holdoff_d      = HOLD_V;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_A;
            select_q       <= 1'b0;
            switch_pulse_q <= 1'b0;
            holdoff_q      <= '0;
        end else begin
            state_q        <= state_d;
            select_q       <= select_d;
            switch_pulse_q <= switch_pulse_d;
            holdoff_q      <= holdoff_d;
        end
    end

    assign select       = select_q;
    assign switch_pulse = switch_pulse_q;
    assign a_healthy    = link_healthy[0];
    assign b_healthy    = link_healthy[1];
    assign state        = state_q;

endmodule

// File: tb/tb_link_failover_ctrl.sv
// Directed bench for link_failover_ctrl. Each expected select change is
// queued when the stimulus that causes it is applied. A negedge monitor pops
// the queue on every switch_pulse and checks the new select value. It also
// checks the idle run on the link being left. Any pulse that arrives with
// nothing queued is an error.
`timescale 1ns/1ps

module tb_link_failover_ctrl;

    localparam int TIMEOUT = 300;
    localparam int WINDOW  = 2048;
    localparam int HOLDOFF = 1024;
    localparam int GAP     = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_dv = 1'b0, a_er = 1'b0, a_up = 1'b0;
    logic       b_dv = 1'b0, b_er = 1'b0, b_up = 1'b0;
    logic       force_en = 1'b0, force_sel = 1'b0;
    logic       select, switch_pulse, a_healthy, b_healthy;
    logic [1:0] state;
    logic       nr_select, nr_switch_pulse, nr_a_healthy, nr_b_healthy;
    logic [1:0] nr_state;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   k = 0;
    int   a_run = 0, b_run = 0;
    int   a_ph = 0, b_ph = 0;
    bit   a_en = 0, b_en = 0, a_stuck = 0;
    int   a_err_left = 0;
    int   pulse_cyc = 0;
    int   t_sw, t_r, t_f;
    logic exp_q[$];

    link_failover_ctrl #(
        .TIMEOUT_CLOCKS(TIMEOUT), .ERR_LIMIT(4), .ERR_WINDOW(WINDOW),
        .HOLDOFF_CLOCKS(HOLDOFF), .GAP_CLOCKS(GAP), .REVERTIVE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_dv(a_dv), .a_er(a_er), .a_up(a_up),
        .b_dv(b_dv), .b_er(b_er), .b_up(b_up),
        .force_en(force_en), .force_sel(force_sel),
        .select(select), .switch_pulse(switch_pulse),
        .a_healthy(a_healthy), .b_healthy(b_healthy), .state(state)
    );

    link_failover_ctrl #(
        .TIMEOUT_CLOCKS(TIMEOUT), .ERR_LIMIT(4), .ERR_WINDOW(WINDOW),
        .HOLDOFF_CLOCKS(HOLDOFF), .GAP_CLOCKS(GAP), .REVERTIVE(0)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n),
        .a_dv(a_dv), .a_er(a_er), .a_up(a_up),
        .b_dv(b_dv), .b_er(b_er), .b_up(b_up),
        .force_en(force_en), .force_sel(force_sel),
        .select(nr_select), .switch_pulse(nr_switch_pulse),
        .a_healthy(nr_a_healthy), .b_healthy(nr_b_healthy), .state(nr_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s did not match", tag);
        end
    endtask

    // Scoreboard consumer: runs on each switch pulse.
    always @(negedge clk) begin
        logic e;
        int   run;
        if (switch_pulse === 1'b1) begin
            pulse_cyc = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $display("FAIL unexpected_switch: observed pulse with select=%0b, required no pulse (cycle %0d)", select, cyc);
                $error("unexpected switch pulse");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (select === e) else begin
                    failures++;
                    $display("FAIL switch_select: observed=%0b expected=%0b (cycle %0d)", select, e, cyc);
                    $error("select after switch wrong");
                end
                run = e ? a_run : b_run;
                checks++;
                assert (run >= GAP) else begin
                    failures++;
                    $display("FAIL switch_gap: observed idle run=%0d expected>=%0d (cycle %0d)", run, GAP, cyc);
                    $error("switch outside gap");
                end
            end
        end
    end

    // Advances one clock, then updates the traffic generators for the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) k++; else k = 0;
        a_run = a_dv ? 0 : a_run + 1;
        b_run = b_dv ? 0 : b_run + 1;
        if (a_en) a_ph = (a_ph + 1) % 40;
        if (b_en) b_ph = (b_ph + 1) % 40;
        a_dv = a_stuck || (a_en && a_ph < 20);
        b_dv = b_en && b_ph < 20;
        if (a_en && a_ph == 5 && a_err_left > 0) begin
            a_er = 1'b1;
            a_err_left--;
        end else begin
            a_er = 1'b0;
        end
        b_er = 1'b0;
    endtask

    task automatic start_traffic();
        a_ph = 0; b_ph = 0; a_en = 1; b_en = 1;
        a_err_left = 0;
        a_dv = 1'b1; b_dv = 1'b1; a_er = 1'b0; b_er = 1'b0;
        a_up = 1'b1; b_up = 1'b1;
    endtask

    task automatic wait_switch(input string tag, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_select", select, 0);
        chk("rst_pulse", switch_pulse, 0);
        chk("rst_a_healthy", a_healthy, 0);
        chk("rst_b_healthy", b_healthy, 0);

        // Both links up with traffic: healthy, stays on A
        rst_n = 1'b1;
        start_traffic();
        repeat (2) tick();
        chk("up_a_healthy", a_healthy, 1);
        chk("up_b_healthy", b_healthy, 1);
        chk("up_select", select, 0);

        // 4 errored A frames split across the window wrap: no switch
        while (k < 1950) tick();
        a_err_left = 4;
        while (k < 2200) tick();
        chk("split_select", select, 0);
        chk("split_a_healthy", a_healthy, 1);

        // 4 errored A frames inside one window: switch to B
        while (k < 2250) tick();
        a_err_left = 4;
        exp_q.push_back(1'b1);
        wait_switch("err_switch", 400);
        t_sw = pulse_cyc;
        chk("err_state", state, 2);
        chk("err_a_healthy", a_healthy, 0);

        // A recovers shortly after the switch: revert only after hold-off plus gap
        repeat (8) tick();
        a_up = 1'b0;
        tick();
        a_up = 1'b1;
        exp_q.push_back(1'b0);
        while (cyc < t_sw + 1000) tick();
        chk("holdoff_select", select, 1);
        chk("holdoff_pending", exp_q.size(), 1);
        wait_switch("revert", 200);
        t_r = pulse_cyc;
        chk("revert_min_delay", (t_r - t_sw) >= HOLDOFF + 2, 1);
        chk("revert_max_delay", (t_r - t_sw) <= HOLDOFF + 66, 1);
        chk("nonrevert_select", nr_select, 1);

        // Forced switch 5 clocks after a switch ignores hold-off
        repeat (4) tick();
        force_en = 1'b1;
        force_sel = 1'b1;
        exp_q.push_back(1'b1);
        wait_switch("force_b", 80);
        t_f = pulse_cyc;
        chk("force_b_fast", (t_f - t_r) <= 100, 1);
        repeat (5) tick();
        force_sel = 1'b0;
        exp_q.push_back(1'b0);
        wait_switch("force_a", 80);
        chk("force_a_fast", (pulse_cyc - t_f) <= 100, 1);
        force_en = 1'b0;
        repeat (100) tick();
        chk("unforced_select", select, 0);
        chk("unforced_state", state, 0);

        // a_up drops during an A frame: switch only after the frame plus gap
        repeat (1100) tick();
        for (int i = 0; i < 40 && a_ph != 3; i++) tick();
        a_up = 1'b0;
        exp_q.push_back(1'b1);
        wait_switch("linkdown", 100);
        chk("linkdown_select", select, 1);

        // Both links down: select held, no pulses
        b_up = 1'b0;
        a_en = 0; b_en = 0;
        a_dv = 1'b0; b_dv = 1'b0;
        repeat (3000) tick();
        chk("bothdown_select", select, 1);
        chk("bothdown_state", state, 2);
        chk("bothdown_a_healthy", a_healthy, 0);
        chk("bothdown_b_healthy", b_healthy, 0);

        // Reset while waiting in S_TO_B
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start_traffic();
        a_stuck = 1;
        a_dv = 1'b1;
        repeat (3) tick();
        chk("rerun_a_healthy", a_healthy, 1);
        force_en = 1'b1;
        force_sel = 1'b1;
        repeat (3) tick();
        chk("to_b_state", state, 1);
        chk("to_b_select", select, 0);
        rst_n = 1'b0;
        tick();
        chk("midrst_state", state, 0);
        chk("midrst_select", select, 0);
        chk("midrst_pulse", switch_pulse, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
